// File: rtl/agp32_mem_sched.sv
// Memory command scheduler for the agp32 pipeline: turns processor commands into
// data/fetch transactions on one memory port, shared with a starvation-protected DMA port.
module agp32_mem_sched #(
  parameter int          INIT_CYCLES  = 4,
  parameter int          STARVE_LIMIT = 8,
  parameter logic [31:0] INST_NOP     = 32'd63
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  command,
  input  logic [31:0] PC,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_wstrb,
  output logic        ready,
  output logic        mem_start_ready,
  output logic [31:0] inst_rdata,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_ack,
  output logic [31:0] dma_rdata
);

  localparam int ICW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam int SCW = $clog2(STARVE_LIMIT + 1);
  localparam logic [ICW-1:0] INIT_LAST  = ICW'(INIT_CYCLES - 1);
  localparam logic [SCW-1:0] STARVE_MAX = SCW'(STARVE_LIMIT);

  localparam logic [2:0] S_INIT  = 3'd0;
  localparam logic [2:0] S_IDLE  = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_FETCH = 3'd3;
  localparam logic [2:0] S_SYNC  = 3'd4;
  localparam logic [2:0] S_DMA   = 3'd5;

  logic [2:0]     state_reg, state_next;
  logic [ICW-1:0] init_cnt_reg, init_cnt_next;
  logic [SCW-1:0] starve_reg, starve_next;
  logic [29:0]    pc_reg, pc_next;
  logic [29:0]    addr_reg, addr_next;
  logic [31:0]    wdata_reg, wdata_next;
  logic [3:0]     wstrb_reg, wstrb_next;
  logic           write_reg, write_next;
  logic           ready_reg, ready_next;
  logic           start_reg, start_next;
  logic [31:0]    inst_reg, inst_next;
  logic [31:0]    data_reg, data_next;
  logic           req_reg, req_next;
  logic           we_reg, we_next;
  logic [29:0]    maddr_reg, maddr_next;
  logic [31:0]    mwdata_reg, mwdata_next;
  logic [3:0]     mwstrb_reg, mwstrb_next;
  logic           dack_reg, dack_next;
  logic [31:0]    drdata_reg, drdata_next;

  logic       cmd_valid;
  logic       dma_pend;
  logic       starved;
  logic       grant_dma;
  logic [3:0] data_strb;
  logic       unused_bits;

  assign cmd_valid = (command != 3'd0);
  // The requester still holds dma_req during the ack cycle; that cycle must not re-grant.
  assign dma_pend  = dma_req && !dack_reg;
  assign starved   = (starve_reg >= STARVE_MAX);
  assign grant_dma = dma_pend && (starved || !cmd_valid);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_strb
      assign data_strb[gi] = write_reg ? wstrb_reg[gi] : 1'b1;
    end
  endgenerate

  assign unused_bits = ^{PC[1:0], data_addr[1:0], dma_addr[1:0]};

  always_comb begin
    state_next    = state_reg;
    init_cnt_next = init_cnt_reg;
    starve_next   = starve_reg;
    pc_next       = pc_reg;
    addr_next     = addr_reg;
    wdata_next    = wdata_reg;
    wstrb_next    = wstrb_reg;
    write_next    = write_reg;
    ready_next    = ready_reg;
    start_next    = start_reg;
    inst_next     = inst_reg;
    data_next     = data_reg;
    req_next      = req_reg;
    we_next       = we_reg;
    maddr_next    = maddr_reg;
    mwdata_next   = mwdata_reg;
    mwstrb_next   = mwstrb_reg;
    dack_next     = 1'b0;
    drdata_next   = drdata_reg;

    case (state_reg)
      S_INIT: begin
        if (init_cnt_reg == INIT_LAST) begin
          state_next = S_IDLE;
          ready_next = 1'b1;
          start_next = 1'b1;
        end else begin
          init_cnt_next = init_cnt_reg + ICW'(1);
        end
      end

      S_IDLE: begin
        if (grant_dma) begin
          ready_next  = 1'b0;
          state_next  = S_DMA;
          starve_next = '0;
        end else if (cmd_valid) begin
          ready_next = 1'b0;
          pc_next    = PC[31:2];
          addr_next  = data_addr[31:2];
          wdata_next = data_wdata;
          wstrb_next = data_wstrb;
          write_next = (command == 3'd3);
          if (dma_pend && !starved) begin
            starve_next = starve_reg + SCW'(1);
          end
          case (command)
            3'd1:       state_next = S_FETCH;
            3'd2, 3'd3: state_next = S_DATA;
            default:    state_next = S_SYNC;
          endcase
        end
      end

      // Each access state spends one cycle launching the request, then waits for mem_ack.
      S_DATA: begin
        if (!req_reg) begin
          req_next    = 1'b1;
          we_next     = write_reg;
          maddr_next  = addr_reg;
          mwdata_next = wdata_reg;
          mwstrb_next = data_strb;
        end else if (mem_ack) begin
          if (!write_reg) begin
            data_next = mem_rdata;
          end
          state_next  = S_FETCH;
          we_next     = 1'b0;
          maddr_next  = pc_reg;
          mwstrb_next = 4'hF;
        end
      end

      S_FETCH: begin
        if (!req_reg) begin
          req_next    = 1'b1;
          we_next     = 1'b0;
          maddr_next  = pc_reg;
          mwstrb_next = 4'hF;
        end else if (mem_ack) begin
          inst_next  = mem_rdata;
          req_next   = 1'b0;
          ready_next = 1'b1;
          state_next = S_IDLE;
        end
      end

      S_SYNC: begin
        ready_next = 1'b1;
        state_next = S_IDLE;
      end

      S_DMA: begin
        if (!req_reg) begin
          req_next    = 1'b1;
          we_next     = dma_we;
          maddr_next  = dma_addr[31:2];
          mwdata_next = dma_wdata;
          mwstrb_next = 4'hF;
        end else if (mem_ack) begin
          dack_next = 1'b1;
          if (!we_reg) begin
            drdata_next = mem_rdata;
          end
          req_next   = 1'b0;
          we_next    = 1'b0;
          ready_next = 1'b1;
          state_next = S_IDLE;
        end
      end

      default: begin
        state_next = S_INIT;
        ready_next = 1'b0;
        req_next   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= S_INIT;
      init_cnt_reg <= '0;
      starve_reg   <= '0;
      pc_reg       <= '0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      wstrb_reg    <= '0;
      write_reg    <= 1'b0;
      ready_reg    <= 1'b0;
      start_reg    <= 1'b0;
      inst_reg     <= INST_NOP;
      data_reg     <= '0;
      req_reg      <= 1'b0;
      we_reg       <= 1'b0;
      maddr_reg    <= '0;
      mwdata_reg   <= '0;
      mwstrb_reg   <= '0;
      dack_reg     <= 1'b0;
      drdata_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      init_cnt_reg <= init_cnt_next;
      starve_reg   <= starve_next;
      pc_reg       <= pc_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
      wstrb_reg    <= wstrb_next;
      write_reg    <= write_next;
      ready_reg    <= ready_next;
      start_reg    <= start_next;
      inst_reg     <= inst_next;
      data_reg     <= data_next;
      req_reg      <= req_next;
      we_reg       <= we_next;
      maddr_reg    <= maddr_next;
      mwdata_reg   <= mwdata_next;
      mwstrb_reg   <= mwstrb_next;
      dack_reg     <= dack_next;
      drdata_reg   <= drdata_next;
    end
  end

  assign ready           = ready_reg;
  assign mem_start_ready = start_reg;
  assign inst_rdata      = inst_reg;
  assign data_rdata      = data_reg;
  assign mem_req         = req_reg;
  assign mem_we          = we_reg;
  assign mem_addr        = maddr_reg;
  assign mem_wdata       = mwdata_reg;
  assign mem_wstrb       = mwstrb_reg;
  assign dma_ack         = dack_reg;
  assign dma_rdata       = drdata_reg;

endmodule

// File: tb/tb_agp32_mem_sched.sv
// Bench for agp32_mem_sched: transaction-level reference model, memory model with
// wait states, directed boundary cases and randomized command/DMA traffic.
module tb_agp32_mem_sched;
  localparam int INIT_CYCLES  = 4;
  localparam int STARVE_LIMIT = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  command = '0;
  logic [31:0] PC = '0, data_addr = '0, data_wdata = '0;
  logic [3:0]  data_wstrb = '0;
  logic        ready, mem_start_ready;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        dma_req = 1'b0, dma_we = 1'b0;
  logic [31:0] dma_addr = '0, dma_wdata = '0;
  logic        dma_ack;
  logic [31:0] dma_rdata;

  always #5 clk = ~clk;

  agp32_mem_sched #(.INIT_CYCLES(INIT_CYCLES), .STARVE_LIMIT(STARVE_LIMIT), .INST_NOP(32'd63)) dut (
    .clk(clk), .rst(rst), .command(command), .PC(PC), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_wstrb(data_wstrb), .ready(ready),
    .mem_start_ready(mem_start_ready), .inst_rdata(inst_rdata), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .dma_req(dma_req),
    .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_ack(dma_ack),
    .dma_rdata(dma_rdata)
  );

  typedef struct {
    logic        we;
    logic [29:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic        chk_strb;
  } txn_t;

  txn_t        exp_q[$];
  logic [31:0] sim_mem [0:63];
  logic [31:0] ref_mem [0:63];
  logic [29:0] addr_log[$];
  logic        we_log[$];
  logic [3:0]  strb_log[$];

  int n_cmp = 0, n_bad = 0;
  int starve = 0;
  bit dma_pend = 0, dma_out = 0, exp_dma_rd = 0;
  logic [31:0] exp_inst = 32'd63, exp_data = '0, exp_dma = '0;
  int dma_acks = 0, req_cycles = 0, force_wait = -1;
  bit zero_wait = 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic finish_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  endtask

  task automatic abort(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired at %0t", name, $time);
    finish_run();
  endtask

  function automatic int widx(input logic [31:0] byte_addr);
    return int'(byte_addr[7:2]);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] st);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic int exp_low(input bit g, input logic [2:0] c);
    if (g || c == 3'd1) return 2;
    if (c == 3'd2 || c == 3'd3) return 3;
    return 1;
  endfunction

  // Memory: acks after a per-request number of wait cycles and checks each transaction.
  initial begin : memory_model
    bit fresh;
    int wait_left;
    txn_t t;
    int i;
    fresh = 1;
    wait_left = 0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (rst) begin
        fresh = 1;
        continue;
      end
      if (mem_req) begin
        req_cycles++;
        if (fresh) begin
          if (force_wait >= 0) begin
            wait_left = force_wait;
            force_wait = -1;
          end else begin
            wait_left = zero_wait ? 0 : int'($urandom_range(0, 3));
          end
          fresh = 0;
        end
        if (wait_left > 0) begin
          wait_left--;
        end else begin
          fresh = 1;
          i = int'(mem_addr[5:0]);
          mem_ack = 1'b1;
          mem_rdata = sim_mem[i];
          if (mem_we) sim_mem[i] = merge(sim_mem[i], mem_wdata, mem_wstrb);
          addr_log.push_back(mem_addr);
          we_log.push_back(mem_we);
          strb_log.push_back(mem_wstrb);
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_txn: got addr %h we %b expected none", mem_addr, mem_we);
          end else begin
            t = exp_q.pop_front();
            chk("txn_we", 32'(mem_we), 32'(t.we));
            chk("txn_addr", 32'(mem_addr), 32'(t.addr));
            if (t.chk_strb) chk("txn_strb", 32'(mem_wstrb), 32'(t.strb));
            if (t.we) chk("txn_wdata", mem_wdata, t.wdata);
          end
        end
      end
    end
  end

  // Compare process: results must match the model whenever the scheduler reports idle.
  initial begin : compare
    forever begin
      @(posedge clk);
      #3;
      if (!rst) begin
        if (ready) begin
          chk("inst_rdata", inst_rdata, exp_inst);
          chk("data_rdata", data_rdata, exp_data);
          chk("start_ready_when_ready", 32'(mem_start_ready), 32'd1);
        end
        if (dma_ack) begin
          dma_acks++;
          chk("dma_ack_expected", 32'(dma_out), 32'd1);
          if (exp_dma_rd) chk("dma_rdata", dma_rdata, exp_dma);
        end
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (!ready) begin
      n++;
      if (n > 100) abort("wait_ready");
      @(negedge clk);
    end
  endtask

  // One arbitration slot, entered and left at a negedge with ready high.
  task automatic do_slot(input logic [2:0] c, input logic [31:0] pc, input logic [31:0] da,
                         input logic [31:0] wd, input logic [3:0] ws, input bit new_dma,
                         input logic dwe, input logic [31:0] dad, input logic [31:0] dwd,
                         output int low, output bit granted);
    bit accept;
    txn_t t;
    if (new_dma && !dma_pend) begin
      dma_req = 1'b1; dma_we = dwe; dma_addr = dad; dma_wdata = dwd; dma_pend = 1;
    end
    command = c; PC = pc; data_addr = da; data_wdata = wd; data_wstrb = ws;
    granted = dma_pend && (starve >= STARVE_LIMIT || c == 3'd0);
    accept  = !granted && (c != 3'd0);
    if (granted) begin
      t.we = dma_we; t.addr = dma_addr[31:2]; t.strb = 4'hF; t.wdata = dma_wdata; t.chk_strb = 1;
      exp_q.push_back(t);
      if (dma_we) ref_mem[widx(dma_addr)] = dma_wdata;
      else exp_dma = ref_mem[widx(dma_addr)];
      exp_dma_rd = !dma_we;
      dma_out = 1;
      starve = 0;
    end else if (accept) begin
      if (dma_pend) starve++;
      if (c == 3'd2 || c == 3'd3) begin
        t.we = (c == 3'd3); t.addr = da[31:2]; t.strb = (c == 3'd3) ? ws : 4'hF;
        t.wdata = wd; t.chk_strb = 1;
        exp_q.push_back(t);
        if (c == 3'd3) ref_mem[widx(da)] = merge(ref_mem[widx(da)], wd, ws);
        else exp_data = ref_mem[widx(da)];
      end
      if (c >= 3'd1 && c <= 3'd3) begin
        t.we = 0; t.addr = pc[31:2]; t.strb = 4'hF; t.wdata = '0; t.chk_strb = 0;
        exp_q.push_back(t);
        exp_inst = ref_mem[widx(pc)];
      end
    end
    @(posedge clk);
    #1;
    command = 3'd0;
    low = 0;
    @(negedge clk);
    if (granted || accept) begin
      while (!ready) begin
        low++;
        if (low > 64) abort("ready_return");
        @(negedge clk);
      end
      chk("ready_dropped", 32'(low > 0), 32'd1);
      if (zero_wait) chk("latency", low, exp_low(granted, c));
      if (granted) begin
        chk("dma_ack_with_ready", 32'(dma_ack), 32'd1);
        dma_req = 1'b0;
        dma_pend = 0;
        dma_out = 0;
        @(negedge clk);
      end
    end else begin
      chk("ready_stays", 32'(ready), 32'd1);
    end
  endtask

  task automatic init_check();
    for (int k = 1; k <= INIT_CYCLES; k++) begin
      @(negedge clk);
      chk("init_ready", 32'(ready), 32'(k == INIT_CYCLES));
      chk("init_start_ready", 32'(mem_start_ready), 32'(k == INIT_CYCLES));
    end
    chk("init_inst_nop", inst_rdata, 32'd63);
    chk("init_data_zero", data_rdata, 32'd0);
  endtask

  initial begin : stimulus
    int low, acc, acks0, req0, wc;
    bit g;
    logic [2:0] c;
    int r;
    for (int i = 0; i < 64; i++) begin
      sim_mem[i] = $urandom;
      ref_mem[i] = sim_mem[i];
    end
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_inst", inst_rdata, 32'd63);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    rst = 1'b0;
    init_check();

    // Read + fetch with zero-wait memory.
    sim_mem[0] = 32'hAAAA0001; ref_mem[0] = 32'hAAAA0001;
    sim_mem[2] = 32'h00000040; ref_mem[2] = 32'h00000040;
    addr_log.delete(); we_log.delete(); strb_log.delete();
    do_slot(3'd2, 32'h8, 32'h100, 32'h0, 4'h0, 0, 0, 0, 0, low, g);
    chk("rd_low3", low, 32'd3);
    chk("rd_data_lit", data_rdata, 32'hAAAA0001);
    chk("rd_inst_lit", inst_rdata, 32'h40);
    chk("rd_addr0_lit", 32'(addr_log[0]), 32'h40);
    chk("rd_addr1_lit", 32'(addr_log[1]), 32'h2);

    // Write + fetch: data_rdata must keep the read value.
    addr_log.delete(); we_log.delete(); strb_log.delete();
    do_slot(3'd3, 32'h10, 32'h204, 32'h55, 4'b0010, 0, 0, 0, 0, low, g);
    chk("wr_low3", low, 32'd3);
    chk("wr_addr_lit", 32'(addr_log[0]), 32'h81);
    chk("wr_we_lit", 32'(we_log[0]), 32'd1);
    chk("wr_strb_lit", 32'(strb_log[0]), 32'b0010);
    chk("wr_fetch_addr_lit", 32'(addr_log[1]), 32'h4);
    chk("wr_data_kept_lit", data_rdata, 32'hAAAA0001);

    // Interrupt sync: one cycle, no memory traffic.
    req0 = req_cycles;
    do_slot(3'd4, 32'h0, 32'h0, 32'h0, 4'h0, 0, 0, 0, 0, low, g);
    chk("sync_low1", low, 32'd1);
    chk("sync_no_req", req_cycles, req0);

    // Starvation: DMA held across back-to-back fetches.
    acc = 0;
    acks0 = dma_acks;
    for (int i = 0; i < 9; i++) begin
      do_slot(3'd1, 32'(4 * i), 32'h0, 32'h0, 4'h0, (i == 0), 1'b0, 32'h40, 32'h0, low, g);
      if (g) chk("starve_grant_slot", i, 32'd8);
      else acc++;
    end
    chk("starve_accepted_lit", acc, 32'd8);
    chk("starve_one_ack_lit", dma_acks - acks0, 32'd1);
    do_slot(3'd1, 32'h20, 32'h0, 32'h0, 4'h0, 0, 0, 0, 0, low, g);
    chk("starve_retry_low", low, 32'd2);

    // Reset in the middle of a stalled read.
    wait_ready();
    force_wait = 5;
    command = 3'd2; data_addr = 32'h20; PC = 32'h30;
    @(posedge clk);
    #1;
    command = 3'd0;
    wc = 0;
    for (int n = 0; n < 20 && wc < 3; n++) begin
      @(negedge clk);
      if (mem_req) wc++;
    end
    if (wc < 3) abort("stall_wait");
    rst = 1'b1;
    exp_q.delete();
    exp_inst = 32'd63; exp_data = '0; starve = 0;
    dma_pend = 0; dma_out = 0; dma_req = 1'b0; force_wait = -1;
    #1;
    chk("mid_rst_ready", 32'(ready), 32'd0);
    chk("mid_rst_start", 32'(mem_start_ready), 32'd0);
    chk("mid_rst_inst", inst_rdata, 32'd63);
    chk("mid_rst_data", data_rdata, 32'd0);
    chk("mid_rst_req", 32'(mem_req), 32'd0);
    chk("mid_rst_we", 32'(mem_we), 32'd0);
    chk("mid_rst_addr", 32'(mem_addr), 32'd0);
    chk("mid_rst_wdata", mem_wdata, 32'd0);
    chk("mid_rst_wstrb", 32'(mem_wstrb), 32'd0);
    chk("mid_rst_dma_ack", 32'(dma_ack), 32'd0);
    chk("mid_rst_dma_rdata", dma_rdata, 32'd0);
    repeat (2) @(negedge clk);
    chk("mid_rst_hold_ready", 32'(ready), 32'd0);
    rst = 1'b0;
    init_check();

    // Randomized traffic: zero-wait memory first, then random wait states.
    for (int i = 0; i < 400; i++) begin
      zero_wait = (i < 150);
      wait_ready();
      r = int'($urandom_range(0, 9));
      if (r < 2) c = 3'd0;
      else if (r < 5) c = 3'd1;
      else if (r < 7) c = 3'd2;
      else if (r < 9) c = 3'd3;
      else c = 3'($urandom_range(4, 7));
      do_slot(c, $urandom_range(0, 255), $urandom_range(0, 255), $urandom,
              4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
              $urandom_range(0, 255), $urandom, low, g);
    end
    repeat (4) @(negedge clk);
    chk("final_queue_empty", exp_q.size(), 32'd0);
    finish_run();
  end

  initial begin : watchdog
    #2000000;
    abort("global_timeout");
  end
endmodule
